fifo_umbrales: RTL and testbench
================================

Name: fifo_umbrales

Overview:
Single-clock synchronous FIFO with programmable low/high occupancy thresholds and a sticky error flag. It is the buffer stage directly upstream of the control state machine. Five instances feed that machine: their empty outputs form Fifo_empties[4:0] and their error outputs form Fifo_errors[4:0]. Threshold inputs are driven by the machine's umbral outputs, which hold during normal operation.

Parameters:
DATA_W, 6, width of each stored word
ADDR_W, 2, pointer width; DEPTH = 2**ADDR_W (default 4 entries)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising edge where reset=1
push  input  1  write request
data_in  input  DATA_W  write data, captured when a push is accepted
pop  input  1  read request
umbral_bajo  input  ADDR_W  low threshold (almost_empty level)
umbral_alto  input  ADDR_W  high threshold (entries-from-full level)
data_out  output  DATA_W  registered read data
valid_out  output  1  data_out holds a word popped on the previous edge
count  output  ADDR_W+1  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
almost_empty  output  1  count <= umbral_bajo
almost_full  output  1  count >= DEPTH - umbral_alto
error  output  1  sticky overflow/underflow flag

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0. Consequently empty=1, full=0, almost_empty=1, almost_full=0 (umbral_alto < DEPTH always holds). Storage array is not reset.
- Reset has priority over push and pop in the same cycle. Asserting it mid-operation discards all contents on that edge.
- Flag outputs empty/full/almost_empty/almost_full are combinational from registered count and the current threshold inputs. Compare using ADDR_W+1-bit unsigned arithmetic. DEPTH - umbral_alto never underflows.
- Push acceptance: push && (!full || pop). Accepted push writes data_in at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop acceptance: pop && !empty. Accepted pop sets data_out <= mem[rd_ptr] and valid_out <= 1 on that edge, so latency is 1 cycle; rd_ptr increments modulo DEPTH.
- No accepted pop in a cycle: valid_out <= 0 and data_out holds its last value.
- Count update: count += accepted push - accepted pop.
- Simultaneous push+pop, 0<count<DEPTH: both are accepted and count is unchanged.
- Push+pop while full: both are accepted, the oldest word is read, the new word goes into the freed slot, and count stays DEPTH. This is not an error.
- Push+pop while empty: only the push is accepted (no bypass), count becomes 1, and error is set (underflow).
- Overflow: push && full && !pop. Data is dropped, pointers are unchanged, and error <= 1.
- Underflow: pop && empty. data_out is unchanged, valid_out <= 0, and error <= 1.
- error is sticky until reset.
- Threshold inputs may change at any time. Flags reflect the new values in the same cycle, with no registering.

Test Plan:
- Reset: hold reset=1 for 2 cycles with push=1 -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, error=0, valid_out=0.
- Fill/drain: umbral_bajo=1, umbral_alto=1, push 0x11,0x22,0x33,0x34 on 4 edges.
  - Flag sequence: count 1..4; almost_empty drops at count=2; almost_full rises at count=3; full at 4.
  - Then pop 4 times: data_out 0x11,0x22,0x33,0x34, each one cycle after its pop with valid_out=1; empty=1 at end; error=0.
- Wrap-around: push 3, pop 3, push 4, pop 4 -> read order matches write order across pointer wrap; count returns to 0; no error.
- Simultaneous cases:
  - Push+pop at count=2: count stays 2, oldest word out.
  - Push+pop at full: count stays 4, error=0.
  - Push+pop at empty: count=1, valid_out=0, error=1.
- Overflow: fill to 4, push 0x3F without pop -> count=4, error=1 and held; subsequent 4 pops return the original 4 words (0x3F absent).
- Underflow then reset mid-operation:
  - Pop when empty -> error=1.
  - Push 2 words, assert reset for 1 cycle -> count=0, empty=1, error=0; next pop gives valid_out=0.

Source files
------------

// File: rtl/fifo_umbrales.sv
// Small FIFO upstream of the control FSM, with threshold flags and a sticky overflow/underflow error.
// Read data is registered one cycle after an accepted pop; push+pop while full is accepted, a push alone while full drops the word.
module fifo_umbrales #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_umbral_bajo,
  input  logic [ADDR_W-1:0] i_umbral_alto,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid_out,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic              o_error
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_error;

  logic            w_empty;
  logic            w_full;
  logic            w_push_ok;
  logic            w_pop_ok;
  logic            w_overflow;
  logic            w_underflow;
  logic [ADDR_W:0] w_af_level;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH);
  // A pop frees a slot in the same edge, so a full FIFO still takes a push paired with a pop.
  assign w_push_ok   = i_push && (!w_full || i_pop);
  assign w_pop_ok    = i_pop && !w_empty;
  assign w_overflow  = i_push && w_full && !i_pop;
  assign w_underflow = i_pop && w_empty;
  assign w_af_level  = DEPTH - {1'b0, i_umbral_alto};

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      r_valid_out <= w_pop_ok;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_overflow || w_underflow) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_data_out     = r_data_out;
  assign o_valid_out    = r_valid_out;
  assign o_count        = r_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_empty = (r_count <= {1'b0, i_umbral_bajo});
  assign o_almost_full  = (r_count >= w_af_level);
  assign o_error        = r_error;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Bench for fifo_umbrales: directed test-plan sequences then random traffic,
// checked against a queue-based model with a tagged scoreboard for read data.
module tb_fifo_umbrales;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [AW-1:0] ub;
  logic [AW-1:0] ua;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          empty, full, almost_empty, almost_full, error;

  fifo_umbrales #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(reset), .i_push(push), .i_data_in(data_in), .i_pop(pop),
    .i_umbral_bajo(ub), .i_umbral_alto(ua),
    .o_data_out(data_out), .o_valid_out(valid_out), .o_count(count),
    .o_empty(empty), .o_full(full), .o_almost_empty(almost_empty),
    .o_almost_full(almost_full), .o_error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: contents as a plain queue, sticky error, last word read.
  int mdl[$];
  bit merr = 1'b0;
  int last_dat = 0;

  typedef struct {
    int tag;
    int dat;
  } exp_t;
  exp_t expq[$];

  function automatic void chk(string name, int act, int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endfunction

  function automatic void check_state();
    int sz;
    sz = mdl.size();
    chk("count", int'(count), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == DEPTH));
    chk("almost_empty", int'(almost_empty), int'(sz <= int'(ub)));
    chk("almost_full", int'(almost_full), int'(sz >= DEPTH - int'(ua)));
    chk("error", int'(error), int'(merr));
    chk("data_out_hold", int'(data_out), last_dat);
  endfunction

  // Scoreboard monitor: each read word is tagged with the cycle it must appear in.
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].tag == cyc) begin
      exp_t e;
      e = expq.pop_front();
      chk("valid_out", int'(valid_out), 1);
      chk("read_data", int'(data_out), e.dat);
    end else if (valid_out === 1'b1) begin
      chk("spurious_valid", 1, 0);
    end
  end

  task automatic step(bit rst, bit ps, bit pp, int d);
    @(negedge clk);
    check_state();
    reset   = rst;
    push    = ps;
    pop     = pp;
    data_in = DW'(d);
    if (rst) begin
      mdl.delete();
      merr = 1'b0;
      last_dat = 0;
    end else begin
      bit was_full;
      was_full = (mdl.size() == DEPTH);
      if (pp) begin
        if (mdl.size() > 0) begin
          exp_t e;
          last_dat = mdl.pop_front();
          e.tag = cyc + 1;
          e.dat = last_dat;
          expq.push_back(e);
        end else begin
          merr = 1'b1;
        end
      end
      if (ps) begin
        if (!was_full || pp) mdl.push_back(d & 6'h3F);
        else merr = 1'b1;
      end
    end
  endtask

  task automatic pushes(int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, int'($urandom_range(0, 63)));
  endtask

  task automatic pops(int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  initial begin
    reset = 1'b1; push = 1'b1; pop = 1'b0; data_in = '0;
    ub = 2'd1; ua = 2'd1;
    // Reset held for two edges with push asserted.
    step(1, 1, 0, 5);
    step(1, 1, 0, 6);
    // Fill and drain with known words.
    step(0, 1, 0, 'h11);
    step(0, 1, 0, 'h22);
    step(0, 1, 0, 'h33);
    step(0, 1, 0, 'h34);
    pops(4);
    step(0, 0, 0, 0);
    // Pointer wrap-around.
    pushes(3); pops(3); pushes(4); pops(4);
    // Simultaneous push+pop at count 2, at full, and at empty.
    pushes(2);
    step(0, 1, 1, 'h2A);
    pushes(2);
    step(0, 1, 1, 'h15);
    pops(4);
    step(0, 1, 1, 'h07);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    // Overflow: the dropped word must never come out.
    pushes(4);
    step(0, 1, 0, 'h3F);
    step(0, 0, 0, 0);
    pops(4);
    step(1, 0, 0, 0);
    // Underflow, then reset in the middle of traffic.
    step(0, 0, 1, 0);
    pushes(2);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Random traffic with moving thresholds and occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ub = AW'($urandom_range(0, 3));
        ua = AW'($urandom_range(0, 3));
      end
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("scoreboard_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
